// File: rtl/xdma_pkg.sv
// ============================================================================
// xdma_pkg : shared XDMA widths, address types and address-generator state.
// Rev 1.0
// ============================================================================
`default_nettype none

package xdma_pkg;

  localparam int unsigned XDMA_ADDR_WIDTH   = 48;
  localparam int unsigned XDMA_STRIDE_WIDTH = 19;
  localparam int unsigned XDMA_BOUND_WIDTH  = 19;
  localparam int unsigned XDMA_NR_DIMENSION = 6;
  localparam int unsigned XDMA_NR_BROADCAST = 4;

  typedef logic [XDMA_ADDR_WIDTH-1:0]   addr_t;
  typedef logic [XDMA_STRIDE_WIDTH-1:0] stride_t;
  typedef logic [XDMA_BOUND_WIDTH-1:0]  bound_t;

  typedef enum logic [1:0] {
    AgIdle = 2'd0,
    AgRun  = 2'd1,
    AgDone = 2'd2
  } xdma_addr_gen_state_e;

endpackage

`default_nettype wire

// File: rtl/xdma_nd_addr_gen_if.sv
// ============================================================================
// xdma_nd_addr_gen_if : job-config and address-beat bundle of the ND generator.
// Rev 1.0
// ============================================================================
`default_nettype none

interface xdma_nd_addr_gen_if
  import xdma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = XDMA_ADDR_WIDTH,
  parameter int unsigned STRIDE_WIDTH = XDMA_STRIDE_WIDTH,
  parameter int unsigned BOUND_WIDTH  = XDMA_BOUND_WIDTH,
  parameter int unsigned NR_DIMENSION = XDMA_NR_DIMENSION,
  parameter int unsigned NR_BROADCAST = XDMA_NR_BROADCAST
) ();

  logic                                 cfg_valid_i;
  logic                                 cfg_ready_o;
  logic [NR_BROADCAST*ADDR_WIDTH-1:0]   cfg_base_i;
  logic [NR_BROADCAST-1:0]              cfg_bcast_en_i;
  logic [NR_DIMENSION*BOUND_WIDTH-1:0]  cfg_bound_i;
  logic [NR_DIMENSION*STRIDE_WIDTH-1:0] cfg_stride_i;
  logic                                 abort_i;
  logic                                 addr_valid_o;
  logic                                 addr_ready_i;
  logic [NR_BROADCAST*ADDR_WIDTH-1:0]   addr_o;
  logic [NR_BROADCAST-1:0]              addr_bcast_en_o;
  logic                                 addr_last_o;
  logic                                 done_o;
  logic                                 busy_o;

  // Driver side: cfg decoder plus AW request builder.
  modport master (
    output cfg_valid_i, cfg_base_i, cfg_bcast_en_i, cfg_bound_i, cfg_stride_i,
    output abort_i, addr_ready_i,
    input  cfg_ready_o, addr_valid_o, addr_o, addr_bcast_en_o, addr_last_o,
    input  done_o, busy_o
  );

  modport slave (
    input  cfg_valid_i, cfg_base_i, cfg_bcast_en_i, cfg_bound_i, cfg_stride_i,
    input  abort_i, addr_ready_i,
    output cfg_ready_o, addr_valid_o, addr_o, addr_bcast_en_o, addr_last_o,
    output done_o, busy_o
  );

endinterface

`default_nettype wire

// File: rtl/xdma_nd_dim_counter.sv
// ============================================================================
// xdma_nd_dim_counter : one temporal dimension; incremental index and offset.
// Rev 1.0
// ============================================================================
`default_nettype none

module xdma_nd_dim_counter
  import xdma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = XDMA_ADDR_WIDTH,
  parameter int unsigned STRIDE_WIDTH = XDMA_STRIDE_WIDTH,
  parameter int unsigned BOUND_WIDTH  = XDMA_BOUND_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    i_clear,
  input  logic                    i_step,
  input  logic [BOUND_WIDTH-1:0]  i_bound,
  input  logic [STRIDE_WIDTH-1:0] i_stride,
  output logic [ADDR_WIDTH-1:0]   o_off,
  output logic                    o_at_max
);

  localparam logic [BOUND_WIDTH-1:0] c_one = {{(BOUND_WIDTH-1){1'b0}}, 1'b1};

  logic [BOUND_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0]  r_off;
  logic [ADDR_WIDTH-1:0]  w_stride_ext;

  assign w_stride_ext = {{(ADDR_WIDTH-STRIDE_WIDTH){1'b0}}, i_stride};

  // Offset tracks idx*stride without a multiplier; wraps modulo 2^ADDR_WIDTH.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_idx <= '0;
      r_off <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
      r_off <= '0;
    end else if (i_step) begin
      r_idx <= r_idx + c_one;
      r_off <= r_off + w_stride_ext;
    end
  end

  assign o_off    = r_off;
  assign o_at_max = (r_idx == (i_bound - c_one));

endmodule

`default_nettype wire

// File: rtl/xdma_nd_addr_gen.sv
// ============================================================================
// xdma_nd_addr_gen : N-dim, M-way broadcast address generator (FSM, carry
// chain, offset adder, broadcast add). XDMA_ADDR_GEN_PERF_EN adds a beat counter.
// Rev 1.0
// ============================================================================
`default_nettype none

module xdma_nd_addr_gen
  import xdma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = XDMA_ADDR_WIDTH,
  parameter int unsigned STRIDE_WIDTH = XDMA_STRIDE_WIDTH,
  parameter int unsigned BOUND_WIDTH  = XDMA_BOUND_WIDTH,
  parameter int unsigned NR_DIMENSION = XDMA_NR_DIMENSION,
  parameter int unsigned NR_BROADCAST = XDMA_NR_BROADCAST
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  xdma_nd_addr_gen_if.slave  bus
`ifdef XDMA_ADDR_GEN_PERF_EN
  ,
  output logic [31:0]        perf_beats_o
`endif
);

  xdma_addr_gen_state_e r_state;
  xdma_addr_gen_state_e w_state_next;

  logic [ADDR_WIDTH-1:0]   r_base   [NR_BROADCAST];
  logic [NR_BROADCAST-1:0] r_bcast_en;
  logic [BOUND_WIDTH-1:0]  r_bound  [NR_DIMENSION];
  logic [STRIDE_WIDTH-1:0] r_stride [NR_DIMENSION];

  logic                    w_cfg_ready;
  logic                    w_addr_valid;
  logic                    w_done;
  logic                    w_busy;
  logic                    w_cfg_hs;
  logic                    w_beat_hs;
  logic                    w_abort;
  logic                    w_any_zero;
  logic                    w_last;
  logic [NR_DIMENSION:0]   w_carry;
  logic [NR_DIMENSION-1:0] w_step;
  logic [NR_DIMENSION-1:0] w_clear;
  logic [NR_DIMENSION-1:0] w_at_max;
  logic [ADDR_WIDTH-1:0]   w_off    [NR_DIMENSION];
  logic [ADDR_WIDTH-1:0]   w_off_sum;
  logic [NR_BROADCAST*ADDR_WIDTH-1:0] w_addr;

  assign w_cfg_hs  = bus.cfg_valid_i & w_cfg_ready;
  assign w_abort   = (r_state == AgRun) & bus.abort_i;
  // Abort wins over a coincident beat handshake: that beat is not consumed.
  assign w_beat_hs = w_addr_valid & bus.addr_ready_i & ~bus.abort_i;

  always_comb begin
    w_any_zero = 1'b0;
    for (int d = 0; d < NR_DIMENSION; d++) begin
      if (bus.cfg_bound_i[d*BOUND_WIDTH +: BOUND_WIDTH] == '0) begin
        w_any_zero = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= AgIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      AgIdle: begin
        if (w_cfg_hs) begin
          w_state_next = w_any_zero ? AgDone : AgRun;
        end
      end
      AgRun: begin
        if (w_abort) begin
          w_state_next = AgIdle;
        end else if (w_beat_hs && w_last) begin
          w_state_next = AgDone;
        end
      end
      AgDone:  w_state_next = AgIdle;
      default: w_state_next = AgIdle;
    endcase
  end

  always_comb begin
    w_cfg_ready  = 1'b0;
    w_addr_valid = 1'b0;
    w_done       = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      AgIdle: begin
        w_cfg_ready = 1'b1;
        w_busy      = 1'b0;
      end
      AgRun:   w_addr_valid = 1'b1;
      AgDone:  w_done       = 1'b1;
      default: w_busy       = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_bcast_en <= '0;
      for (int b = 0; b < NR_BROADCAST; b++) r_base[b] <= '0;
      for (int d = 0; d < NR_DIMENSION; d++) begin
        r_bound[d]  <= '0;
        r_stride[d] <= '0;
      end
    end else if (w_cfg_hs) begin
      r_bcast_en <= bus.cfg_bcast_en_i;
      for (int b = 0; b < NR_BROADCAST; b++) begin
        r_base[b] <= bus.cfg_base_i[b*ADDR_WIDTH +: ADDR_WIDTH];
      end
      for (int d = 0; d < NR_DIMENSION; d++) begin
        r_bound[d]  <= bus.cfg_bound_i[d*BOUND_WIDTH +: BOUND_WIDTH];
        r_stride[d] <= bus.cfg_stride_i[d*STRIDE_WIDTH +: STRIDE_WIDTH];
      end
    end
  end

  // carry[d] is set when every dimension below d sits at its final index.
  assign w_carry[0] = 1'b1;

  generate
    for (genvar d = 0; d < NR_DIMENSION; d++) begin : g_dim
      assign w_carry[d+1] = w_carry[d] & w_at_max[d];
      assign w_step[d]    = w_beat_hs & w_carry[d] & ~w_at_max[d];
      assign w_clear[d]   = w_cfg_hs | (w_beat_hs & w_carry[d] & w_at_max[d]);

      xdma_nd_dim_counter #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .STRIDE_WIDTH (STRIDE_WIDTH),
        .BOUND_WIDTH  (BOUND_WIDTH)
      ) u_dim_counter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_clear  (w_clear[d]),
        .i_step   (w_step[d]),
        .i_bound  (r_bound[d]),
        .i_stride (r_stride[d]),
        .o_off    (w_off[d]),
        .o_at_max (w_at_max[d])
      );
    end
  endgenerate

  assign w_last = (r_state == AgRun) & w_carry[NR_DIMENSION];

  always_comb begin
    w_off_sum = '0;
    for (int d = 0; d < NR_DIMENSION; d++) begin
      w_off_sum = w_off_sum + w_off[d];
    end
  end

  always_comb begin
    w_addr = '0;
    for (int b = 0; b < NR_BROADCAST; b++) begin
      w_addr[b*ADDR_WIDTH +: ADDR_WIDTH] = r_base[b] + w_off_sum;
    end
  end

`ifdef XDMA_ADDR_GEN_PERF_EN
  logic [31:0] r_perf_beats;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_perf_beats <= '0;
    end else if (w_beat_hs && (r_perf_beats != 32'hFFFF_FFFF)) begin
      r_perf_beats <= r_perf_beats + 32'd1;
    end
  end

  assign perf_beats_o = r_perf_beats;
`endif

  assign bus.cfg_ready_o     = w_cfg_ready;
  assign bus.addr_valid_o    = w_addr_valid;
  assign bus.addr_o          = w_addr;
  assign bus.addr_bcast_en_o = r_bcast_en;
  assign bus.addr_last_o     = w_last;
  assign bus.done_o          = w_done;
  assign bus.busy_o          = w_busy;

endmodule

`default_nettype wire
